// File: rtl/cone_bist_ctrl.sv
// BIST sequencer for a single-output combinational cone: LFSR-driven inputs,
// programmable settle time, CRC-0x1021 serial signature and golden compare.
module cone_bist_ctrl #(
  parameter int unsigned N_IN   = 31,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] NUM_PAT,
  input  logic [N_IN-1:0]  SEED,
  input  logic [SIG_W-1:0] GOLDEN,
  input  logic             PO,
  output logic [N_IN-1:0]  PI,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIGNATURE,
  output logic [CNT_W-1:0] PAT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CAPTURE,
    S_FIN
  } state_t;

  localparam logic [SIG_W-1:0] POLY        = SIG_W'(16'h1021);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  lfsr_q, lfsr_d;
  logic [N_IN-1:0]  pi_q, pi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_pat_q, num_pat_d;
  logic [3:0]       settle_q, settle_d;

  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [N_IN-1:0]  lfsr_next;

  always_comb begin
    sig_next  = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ PO) ? POLY : '0);
    cnt_inc   = cnt_q + 1'b1;
    lfsr_next = {lfsr_q[N_IN-2:0], lfsr_q[30] ^ lfsr_q[27]};

    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pi_d      = pi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    num_pat_d = num_pat_q;
    settle_d  = settle_q;

    if (state_q != S_IDLE && ABORT) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d   = S_LOAD;
            busy_d    = 1'b1;
            num_pat_d = NUM_PAT;
            // seed goes straight into the LFSR; it is only observable once LOAD copies it to PI
            lfsr_d    = (SEED == '0) ? N_IN'(1) : SEED;
          end
        end
        S_LOAD: begin
          sig_d    = '0;
          cnt_d    = '0;
          settle_d = '0;
          if (num_pat_q == '0) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (GOLDEN == '0);
          end else begin
            state_d = S_APPLY;
            pass_d  = 1'b0;
            pi_d    = lfsr_q;
          end
        end
        S_APPLY: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = S_CAPTURE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        S_CAPTURE: begin
          sig_d  = sig_next;
          cnt_d  = cnt_inc;
          lfsr_d = lfsr_next;
          if (cnt_inc == num_pat_q) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_next == GOLDEN);
          end else begin
            state_d = S_APPLY;
            pi_d    = lfsr_next;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      lfsr_q    <= '0;
      pi_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      sig_q     <= '0;
      cnt_q     <= '0;
      num_pat_q <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pi_q      <= pi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      num_pat_q <= num_pat_d;
      settle_q  <= settle_d;
    end
  end

  assign PI        = pi_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIGNATURE = sig_q;
  assign PAT_CNT   = cnt_q;

endmodule

// File: tb/tb_cone_bist_ctrl.sv
// Scoreboard bench for cone_bist_ctrl: a pattern-level model predicts each
// run's result; a monitor checks it whenever DONE pulses.
module tb_cone_bist_ctrl;

  localparam logic [30:0] CONE_MASK = 31'h5A5A_3C3C;

  logic        CK = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [15:0] NUM_PAT = '0;
  logic [30:0] SEED = '0;
  logic [15:0] GOLDEN = '0;
  logic        PO;
  logic [30:0] PI;
  logic        BUSY, DONE, PASS;
  logic [15:0] SIGNATURE, PAT_CNT;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned po_mode = 0;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        pass;
    logic [30:0] pi;
    bit          chk_pi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cone_bist_ctrl #(.N_IN(31), .SIG_W(16), .CNT_W(16), .SETTLE(2)) dut (
    .CK(CK), .RSTN(RSTN), .START(START), .ABORT(ABORT), .NUM_PAT(NUM_PAT),
    .SEED(SEED), .GOLDEN(GOLDEN), .PO(PO), .PI(PI), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .SIGNATURE(SIGNATURE), .PAT_CNT(PAT_CNT)
  );

  always #5 CK = ~CK;

  function automatic logic po_fn(input int unsigned mode, input logic [30:0] p);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return (^(p & CONE_MASK)) ^ (p[3] & p[17]);
  endfunction

  assign PO = po_fn(po_mode, PI);

  // Pattern-by-pattern model: integer shifts for the LFSR and the CRC
  function automatic exp_t model(input logic [30:0] seed, input int unsigned n,
                                 input logic [15:0] golden, input int unsigned mode);
    exp_t e;
    int unsigned l, s, fb;
    l = (seed == 0) ? 1 : int'(seed);
    s = 0;
    e.pi = '0;
    e.chk_pi = (n != 0);
    for (int unsigned i = 0; i < n; i++) begin
      e.pi = 31'(l);
      fb = ((s >> 15) & 1) ^ int'(po_fn(mode, 31'(l)));
      s = ((s << 1) & 32'hFFFF) ^ (fb != 0 ? 32'h1021 : 32'h0);
      l = ((l << 1) & 32'h7FFF_FFFF) | (((l >> 30) ^ (l >> 27)) & 1);
    end
    e.sig  = 16'(s);
    e.cnt  = 16'(n);
    e.pass = (16'(s) == golden);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CK) begin
    if (RSTN && DONE) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(DONE), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("signature", 32'(SIGNATURE), 32'(mon_e.sig));
        chk("pat_cnt", 32'(PAT_CNT), 32'(mon_e.cnt));
        chk("pass", 32'(PASS), 32'(mon_e.pass));
        chk("busy_at_done", 32'(BUSY), 32'd0);
        if (mon_e.chk_pi) chk("pi_last", 32'(PI), 32'(mon_e.pi));
      end
    end
  end

  task automatic pulse_start(input logic [30:0] seed, input int unsigned n, input logic [15:0] golden);
    @(negedge CK);
    SEED = seed; NUM_PAT = 16'(n); GOLDEN = golden; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned c = 0; c < budget && !seen; c++) begin
      @(negedge CK);
      seen = DONE;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no DONE, expected DONE within %0d cycles", budget);
    end
  endtask

  task automatic run_check(input logic [30:0] seed, input int unsigned n,
                           input logic [15:0] golden, input int unsigned mode);
    po_mode = mode;
    exp_q.push_back(model(seed, n, golden, mode));
    pulse_start(seed, n, golden);
    wait_done(n * 3 + 10);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pi"}, 32'(PI), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_pass"}, 32'(PASS), 32'd0);
    chk({tag, "_sig"}, 32'(SIGNATURE), 32'd0);
    chk({tag, "_cnt"}, 32'(PAT_CNT), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [30:0] s;
    exp_t e;
    int unsigned n, mode;
    logic [15:0] g;

    repeat (3) @(negedge CK);
    check_reset_state("reset");
    RSTN = 1'b1;

    // Zero patterns: one BUSY cycle then DONE, PASS reflects GOLDEN==0
    po_mode = 0;
    exp_q.push_back(model(31'h55, 0, 16'h0000, 0));
    pulse_start(31'h55, 0, 16'h0000);
    chk("n0_busy_load", 32'(BUSY), 32'd1);
    @(negedge CK);
    chk("n0_done", 32'(DONE), 32'd1);

    // SEED=1, two patterns, PO=1: fixed PI/signature timeline
    po_mode = 1;
    exp_q.push_back(model(31'h1, 2, 16'h3063, 1));
    pulse_start(31'h1, 2, 16'h3063);
    @(negedge CK);
    chk("pi_first", 32'(PI), 32'h1);
    repeat (2) @(negedge CK);
    chk("pi_held", 32'(PI), 32'h1);
    @(negedge CK);
    chk("pi_second", 32'(PI), 32'h2);
    chk("sig_first", 32'(SIGNATURE), 32'h1021);
    repeat (3) @(negedge CK);
    chk("done_k7", 32'(DONE), 32'd1);
    chk("sig_second", 32'(SIGNATURE), 32'h3063);
    chk("pass_k7", 32'(PASS), 32'd1);
    START = 1'b1; NUM_PAT = 16'd5;
    @(negedge CK);
    START = 1'b0;
    chk("start_in_fin_ignored", 32'(BUSY), 32'd0);

    // Zero seed substitutes 1
    run_check(31'h0, 1, 16'h0000, 0);

    // Abort during the 4th APPLY
    s = 31'($urandom);
    po_mode = 2;
    pulse_start(s, 10, 16'h1234);
    repeat (10) @(negedge CK);
    ABORT = 1'b1;
    @(negedge CK);
    ABORT = 1'b0;
    e = model(s, 3, 16'h1234, 2);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_pass", 32'(PASS), 32'd0);
    chk("abort_cnt", 32'(PAT_CNT), 32'd3);
    chk("abort_sig", 32'(SIGNATURE), 32'(e.sig));
    repeat (4) @(negedge CK);
    ABORT = 1'b1;
    @(negedge CK);
    ABORT = 1'b0;
    chk("idle_abort_sig", 32'(SIGNATURE), 32'(e.sig));
    run_check(s, 10, 16'h0000, 2);

    // START and ABORT together in IDLE: START wins
    s = 31'($urandom);
    exp_q.push_back(model(s, 2, 16'hFFFF, 2));
    @(negedge CK);
    SEED = s; NUM_PAT = 16'd2; GOLDEN = 16'hFFFF; START = 1'b1; ABORT = 1'b1;
    @(negedge CK);
    START = 1'b0; ABORT = 1'b0;
    chk("start_beats_abort", 32'(BUSY), 32'd1);
    wait_done(20);

    // Reset in the middle of the first CAPTURE
    pulse_start(31'h1ABC, 5, 16'h0);
    repeat (3) @(negedge CK);
    RSTN = 1'b0;
    @(negedge CK);
    RSTN = 1'b1;
    check_reset_state("midrun_reset");

    // START while BUSY is ignored
    s = 31'($urandom);
    exp_q.push_back(model(s, 3, 16'h0, 2));
    pulse_start(s, 3, 16'h0);
    repeat (2) @(negedge CK);
    START = 1'b1; NUM_PAT = 16'd7; SEED = ~s;
    @(negedge CK);
    START = 1'b0;
    wait_done(20);

    // All-ones seed with the reference cone
    e = model(31'h7FFF_FFFF, 4, 16'h0, 2);
    run_check(31'h7FFF_FFFF, 4, e.sig, 2);

    for (int unsigned r = 0; r < 8; r++) begin
      s = 31'($urandom);
      n = $urandom_range(0, 20);
      mode = $urandom_range(0, 2);
      e = model(s, n, 16'h0, mode);
      g = ($urandom_range(0, 1) == 1) ? e.sig : 16'($urandom);
      run_check(s, n, g, mode);
    end

    repeat (5) @(negedge CK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cone_bist_ctrl.md
Name: cone_bist_ctrl

Overview:
- Built-in self-test sequencer for one single-output combinational cone, such as a partial-output slice of an ISCAS89 benchmark with 31 primary inputs.
- Drives the cone inputs from a 31-bit maximal-length LFSR.
- Waits a programmable settle time, then captures the 1-bit cone output into a 16-bit serial signature register.
- Repeats for NUM_PAT patterns and reports the signature plus a pass/fail compare against a golden value.

Parameters:
- N_IN, 31, cone input width; the LFSR taps below are defined only for 31.
- SIG_W, 16, signature width; the polynomial is fixed at 0x1021.
- CNT_W, 16, pattern counter width.
- SETTLE, 2, cycles the cone inputs are held before capture; legal range 1..15.

Ports:
- CK in 1: single clock, rising edge.
- RSTN in 1: synchronous, active-low reset.
- START in 1: begin a run; sampled only in IDLE.
- ABORT in 1: cancel a run; highest priority after reset.
- NUM_PAT in CNT_W: number of patterns; sampled in the START cycle.
- SEED in N_IN: LFSR seed; sampled in the START cycle.
- GOLDEN in SIG_W: expected signature; sampled in the CAPTURE cycle of the last pattern.
- PO in 1: cone output.
- PI out N_IN: cone inputs; registered.
- BUSY out 1: run in progress.
- DONE out 1: one-cycle pulse at end of run.
- PASS out 1: signature equals GOLDEN; valid from DONE until the next START.
- SIGNATURE out SIG_W: compacted result.
- PAT_CNT out CNT_W: patterns captured so far.

Behaviour:
- Clocking and reset: one clock CK. Reset is synchronous and active-low on RSTN. When RSTN=0 at a CK edge, all state is cleared: state=IDLE, PI=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, PAT_CNT=0, internal settle counter=0. Reset mid-run discards the run.
- States: IDLE, LOAD, APPLY, CAPTURE, FIN.
- IDLE: BUSY=0. START=1 -> LOAD. The NUM_PAT and SEED values are latched internally.
- LOAD (1 cycle), BUSY=1:
  - lfsr <= SEED, or 1 if SEED==0 (the all-zero lock-up state is forbidden).
  - SIGNATURE <= 0, PAT_CNT <= 0, PASS <= 0.
  - If NUM_PAT==0 -> FIN; else -> APPLY.
- APPLY: PI = lfsr, loaded on entry and stable through CAPTURE. Stay exactly SETTLE cycles, then -> CAPTURE.
- CAPTURE (1 cycle):
  - Signature update: fb = SIGNATURE[15] ^ PO; SIGNATURE <= {SIGNATURE[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - PAT_CNT <= PAT_CNT+1.
  - LFSR step (Fibonacci, x^31+x^28+1): lfsr <= {lfsr[29:0], lfsr[30]^lfsr[27]}.
  - If PAT_CNT+1 == NUM_PAT -> FIN, with PASS <= (next SIGNATURE == GOLDEN). Else -> APPLY.
- FIN (1 cycle): DONE=1, BUSY=0, then -> IDLE. SIGNATURE, PAT_CNT, PASS and PI hold until the next START.
- Latency: with START sampled at edge k, DONE is high in the cycle after edge k+1+NUM_PAT*(SETTLE+1). For NUM_PAT=0, DONE is high in the cycle after edge k+1.
- ABORT=1 in any non-IDLE state -> IDLE next edge. DONE stays 0, PASS=0. SIGNATURE and PAT_CNT freeze at their current values. ABORT in IDLE is ignored.
- Simultaneous events:
  - START and ABORT both high in IDLE: START wins.
  - START while BUSY: ignored.
  - START during FIN: ignored; a new START is accepted in IDLE on the following cycle.
- PAT_CNT does not wrap within a run, since NUM_PAT ≤ 2^CNT_W−1. The LFSR period 2^31−1 exceeds any legal run.
- PO is sampled only in CAPTURE; its value in other states is don't-care.

Test Plan:
- Reset then NUM_PAT=0, START: BUSY high for 1 cycle, then DONE pulse; SIGNATURE=0x0000, PAT_CNT=0, PASS=(GOLDEN==0).
- SEED=1, NUM_PAT=2, SETTLE=2, PO tied 1, GOLDEN=0x3063:
  - PI=0x00000001 for 3 cycles, then PI=0x00000002.
  - SIGNATURE=0x1021 after the first capture, 0x3063 after the second.
  - PASS=1; DONE in the cycle after edge k+7.
- SEED=0, NUM_PAT=1, PO tied 0: PI=0x00000001 (zero-seed substitution); SIGNATURE=0x0000; PAT_CNT=1.
- NUM_PAT=10, assert ABORT during the 4th APPLY: IDLE next cycle, no DONE pulse, PAT_CNT=3, PASS=0. A fresh START then runs normally.
- RSTN=0 for one edge mid-CAPTURE: all outputs return to their reset values the next cycle. START is ignored while BUSY=1 and accepted in IDLE.
- NUM_PAT=4, SEED=0x7FFFFFFF, PO driven as a reference-model cone: PI sequence matches the x^31+x^28+1 model, and SIGNATURE matches the CRC-0x1021 model bit-exactly.
